// File: rtl/ef_spi_shift_engine.sv
// SPI master shift engine: one DW-bit word per accepted go, all four CPOL/CPHA modes.
// Latency: done appears (2*DW+1)*(clk_divider+1)+1 cycles after the go edge.
// Backpressure: go is accepted only in IDLE/DONE; go while busy is dropped. Option: EF_SPI_LSB_FIRST_EN.
module ef_spi_shift_engine #(
    parameter int DW  = 8,
    parameter int CDW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           CPOL,
    input  logic           CPHA,
    input  logic [CDW-1:0] clk_divider,
    input  logic           go,
    input  logic [DW-1:0]  datai,
    output logic [DW-1:0]  datao,
    output logic           busy,
    output logic           done,
    input  logic           miso,
    output logic           mosi,
`ifdef EF_SPI_LSB_FIRST_EN
    input  logic           lsb_first,
`endif
    output logic           sclk
);
    localparam int EW = $clog2(2*DW) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2*DW);
    localparam logic [EW-1:0] PENULT_EDGE = EW'(2*DW - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_nxt;
    logic [CDW-1:0]  div_l, div_cnt;
    logic [EW-1:0]   edge_cnt;
    logic [DW-1:0]   tx_sr, rx_sr;
    logic            cpha_l, lsb_l, lsb_in;
    logic            accept, tick, last, sample;

`ifdef EF_SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic [DW-1:0] shift_tx(input logic [DW-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic head_bit(input logic [DW-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DW-1];
    endfunction

    function automatic logic [DW-1:0] push_rx(input logic [DW-1:0] v, input logic m,
                                              input logic lsb);
        return lsb ? {m, v[DW-1:1]} : {v[DW-2:0], m};
    endfunction

    assign accept = go && (state != SHIFT);
    assign tick   = (state == SHIFT) && (div_cnt == div_l);
    assign last   = (edge_cnt == LAST_EDGE);
    // CPHA=0 samples on leading (odd) edges, CPHA=1 on trailing (even) edges
    assign sample = ~edge_cnt[0] ^ cpha_l;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (tick && last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = accept ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_l    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
            datao    <= '0;
            mosi     <= 1'b0;
            sclk     <= 1'b0;
        end else if (accept) begin
            div_l    <= clk_divider;
            cpha_l   <= CPHA;
            lsb_l    <= lsb_in;
            div_cnt  <= '0;
            edge_cnt <= '0;
            rx_sr    <= '0;
            sclk     <= CPOL;
            if (!CPHA) begin
                mosi  <= head_bit(datai, lsb_in);
                tx_sr <= shift_tx(datai, lsb_in);
            end else begin
                tx_sr <= datai;
            end
        end else if (state == SHIFT) begin
            if (tick) begin
                div_cnt <= '0;
                if (!last) begin
                    sclk     <= ~sclk;
                    edge_cnt <= edge_cnt + 1'b1;
                    if (sample) begin
                        rx_sr <= push_rx(rx_sr, miso, lsb_l);
                    end else if (edge_cnt != PENULT_EDGE) begin
                        mosi  <= head_bit(tx_sr, lsb_l);
                        tx_sr <= shift_tx(tx_sr, lsb_l);
                    end
                end else begin
                    // end of the hold half-period: publish the word as DONE is entered
                    datao <= rx_sr;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else begin
            sclk <= CPOL;
        end
    end
endmodule
